seg_scan_decoder: RTL and testbench
===================================

SEG_SCAN_DECODER -- requirements
Module: seg_scan_decoder

Interface
REQ-001 The module SHALL take parameter STABLE_CYCLES, default 4, the number of consecutive identical samples required to accept a digit (legal range 2..255).
REQ-002 The module SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The module SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-004 The module SHALL have port seg, input, 7 bits: active-high segment lines, seg[6]=a down to seg[0]=g.
REQ-005 The module SHALL have port dig_en, input, 4 bits: active-high digit strobe, where bit n selects digit n and digit 0 is the least significant.
REQ-006 The module SHALL have port bcd_out, output, 16 bits: captured frame, where bcd_out[4n+3:4n] is digit n.
REQ-007 The module SHALL have port bcd_valid, output, 1 bit: frame available.
REQ-008 The module SHALL have port bcd_ready, input, 1 bit: consumer accepts the frame.
REQ-009 The module SHALL have port seg_err, output, 1 bit: one-cycle pulse when an accepted digit has an illegal pattern.
REQ-010 The module SHALL have port overrun, output, 1 bit: sticky flag set when a completed frame is dropped.

Function
REQ-011 The module SHALL register seg and dig_en each cycle and operate only on the registered copies.
REQ-012 A sample SHALL be qualifying only if dig_en has exactly one bit set.
REQ-013 The per-sample FSM SHALL have three states: IDLE, SETTLE and HOLD.
  - IDLE: goes to SETTLE with count=1 on a qualifying sample.
  - SETTLE: increments count while the sample is qualifying and equal to the previous sample; when count reaches STABLE_CYCLES it captures and goes to HOLD.
  - HOLD: stays until the sample changes.
REQ-014 In SETTLE or HOLD, a non-qualifying sample SHALL move the FSM to IDLE, and a changed qualifying sample SHALL restart SETTLE with count=1.
REQ-015 A capture SHALL occur exactly once per stable pattern: no recapture in HOLD, and exactly one capture in the cycle count reaches STABLE_CYCLES.
REQ-016 Decoding SHALL use this table (abcdefg -> digit):
  - 1111110 -> 0; 0110000 -> 1; 1101101 -> 2; 1111001 -> 3; 0110011 -> 4
  - 1011011 -> 5; 1011111 -> 6; 1110000 -> 7; 1111111 -> 8; 1111011 -> 9
  - any other pattern -> 4'hF, with seg_err pulsed in the capture cycle.
REQ-017 A capture SHALL write the decoded nibble into frame slot n and set mask bit n; recapturing a digit already in the mask SHALL overwrite its slot.
REQ-018 When the mask becomes 4'b1111, the frame SHALL transfer to bcd_out on the next rising edge, with bcd_valid high from then on, provided the output is empty or is being consumed (bcd_valid and bcd_ready) in that same cycle; the mask then clears.
REQ-019 If the output is occupied and not being consumed at completion, the module SHALL drop the frame, clear the mask and set overrun.
REQ-020 bcd_valid and bcd_out SHALL stay stable until a cycle with bcd_valid and bcd_ready; bcd_valid SHALL then fall unless a new frame loads in that same cycle.
REQ-021 overrun SHALL clear only on reset.
REQ-022 Frame-to-output latency SHALL be 1 cycle from the completing capture; input-to-capture latency SHALL be STABLE_CYCLES+1 cycles, including the input register.

Reset
REQ-023 rst SHALL asynchronously force the following:
  - FSM to IDLE, count=0, mask=0 and input registers to 0
  - bcd_out=16'h0000, bcd_valid=0, seg_err=0, overrun=0
REQ-024 Asserting rst mid-frame SHALL discard the partial frame, and capture SHALL resume from IDLE after release.

Structure
REQ-025 A shared package seg_pkg SHALL hold the 7-bit segment pattern constants for digits 0-9, the SEG_ILLEGAL nibble 4'hF, and the FSM state enumeration.
REQ-026 Pattern-to-digit decoding SHALL be one combinational sub-module, seg_to_bcd (seg[6:0] -> bcd[3:0], illegal), instantiated once.

Verification
REQ-027 Scan digits 0..3 with patterns 1111001, 0110011, 1011011, 1011111, each held 6 cycles, with bcd_ready=1 -> bcd_out=16'h6543, bcd_valid high for exactly 1 cycle, no seg_err.
REQ-028 Hold dig_en=4'b0001 with seg=1111110 for 3 cycles (STABLE_CYCLES=4), then change seg -> no capture and mask stays 0.
REQ-029 Send digit 2 with seg=1000001 in a full frame -> seg_err pulses once and bcd_out[11:8]=4'hF.
REQ-030 Drive dig_en=4'b0011 with a valid pattern for 10 cycles -> no capture.
REQ-031 Complete two frames with bcd_ready=0 -> the first frame is held, overrun=1, and bcd_out stays the first frame after bcd_ready rises.
REQ-032 Assert rst after 2 of 4 digits are captured, then send a full frame of 9,8,7,6 -> bcd_out=16'h6789 with no trace of the earlier digits.

Source files
------------

// File: rtl/seg_pkg.sv
// Shared constants for the seven-segment scan decoder: segment patterns,
// the illegal-digit nibble and the scan FSM state encoding.
package seg_pkg;

  // Patterns are abcdefg, seg[6]=a down to seg[0]=g, active high.
  localparam logic [6:0] SEG_0 = 7'b1111110;
  localparam logic [6:0] SEG_1 = 7'b0110000;
  localparam logic [6:0] SEG_2 = 7'b1101101;
  localparam logic [6:0] SEG_3 = 7'b1111001;
  localparam logic [6:0] SEG_4 = 7'b0110011;
  localparam logic [6:0] SEG_5 = 7'b1011011;
  localparam logic [6:0] SEG_6 = 7'b1011111;
  localparam logic [6:0] SEG_7 = 7'b1110000;
  localparam logic [6:0] SEG_8 = 7'b1111111;
  localparam logic [6:0] SEG_9 = 7'b1111011;

  localparam logic [3:0] SEG_ILLEGAL = 4'hF;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_HOLD   = 2'd2
  } scan_state_e;

endpackage

// File: rtl/seg_to_bcd.sv
// Combinational seven-segment pattern to BCD digit decoder.
module seg_to_bcd
  import seg_pkg::*;
(
  input  logic [6:0] seg,
  output logic [3:0] bcd,
  output logic       illegal
);

  always_comb begin
    bcd     = SEG_ILLEGAL;
    illegal = 1'b0;
    case (seg)
      SEG_0:   bcd = 4'd0;
      SEG_1:   bcd = 4'd1;
      SEG_2:   bcd = 4'd2;
      SEG_3:   bcd = 4'd3;
      SEG_4:   bcd = 4'd4;
      SEG_5:   bcd = 4'd5;
      SEG_6:   bcd = 4'd6;
      SEG_7:   bcd = 4'd7;
      SEG_8:   bcd = 4'd8;
      SEG_9:   bcd = 4'd9;
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/seg_scan_decoder.sv
// Samples a multiplexed seven-segment display, debounces each digit strobe,
// decodes it to BCD and hands complete 4-digit frames out on valid/ready.
module seg_scan_decoder
  import seg_pkg::*;
#(
  parameter int STABLE_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [6:0]  seg,
  input  logic [3:0]  dig_en,
  output logic [15:0] bcd_out,
  output logic        bcd_valid,
  input  logic        bcd_ready,
  output logic        seg_err,
  output logic        overrun
);

  // Output handshake: a frame is offered while bcd_valid is high and is
  // consumed on any rising edge where bcd_valid && bcd_ready; bcd_out is
  // held stable until then.

  localparam logic [7:0] STABLE_C = 8'(STABLE_CYCLES);

  logic [6:0]  seg_in_q, seg_in_d, seg_prev_q, seg_prev_d;
  logic [3:0]  en_in_q, en_in_d, en_prev_q, en_prev_d;
  scan_state_e state_q, state_d;
  logic [7:0]  count_q, count_d;
  logic [3:0]  mask_q, mask_d;
  logic [15:0] frame_q, frame_d;
  logic [15:0] bcd_out_q, bcd_out_d;
  logic        bcd_valid_q, bcd_valid_d;
  logic        seg_err_q, seg_err_d;
  logic        overrun_q, overrun_d;

  logic        qual, same, capture, complete, load;
  logic [7:0]  count_inc;
  logic [1:0]  dig_idx;
  logic [3:0]  dec_bcd;
  logic        dec_illegal;

  seg_to_bcd u_dec (
    .seg     (seg_in_q),
    .bcd     (dec_bcd),
    .illegal (dec_illegal)
  );

  assign qual      = (en_in_q != 4'b0) && ((en_in_q & (en_in_q - 4'd1)) == 4'b0);
  assign same      = (seg_in_q == seg_prev_q) && (en_in_q == en_prev_q);
  assign count_inc = count_q + 8'd1;

  always_comb begin
    dig_idx = 2'd0;
    case (en_in_q)
      4'b0010: dig_idx = 2'd1;
      4'b0100: dig_idx = 2'd2;
      4'b1000: dig_idx = 2'd3;
      default: dig_idx = 2'd0;
    endcase
  end

  // Sample FSM: the previous registered sample is kept every cycle so that
  // "unchanged" is always judged against the immediately preceding sample.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    capture = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (qual) begin
          state_d = ST_SETTLE;
          count_d = 8'd1;
        end
      end
      ST_SETTLE: begin
        if (!qual) begin
          state_d = ST_IDLE;
          count_d = 8'd0;
        end else if (!same) begin
          count_d = 8'd1;
        end else begin
          count_d = count_inc;
          if (count_inc == STABLE_C) begin
            capture = 1'b1;
            state_d = ST_HOLD;
          end
        end
      end
      ST_HOLD: begin
        if (!qual) begin
          state_d = ST_IDLE;
          count_d = 8'd0;
        end else if (!same) begin
          state_d = ST_SETTLE;
          count_d = 8'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        count_d = 8'd0;
      end
    endcase
  end

  always_comb begin
    seg_in_d   = seg;
    en_in_d    = dig_en;
    seg_prev_d = seg_in_q;
    en_prev_d  = en_in_q;
    complete   = (mask_q == 4'hF);
    load       = complete && (!bcd_valid_q || bcd_ready);
    frame_d    = frame_q;
    mask_d     = complete ? 4'b0 : mask_q;
    if (capture) begin
      frame_d[{dig_idx, 2'b00} +: 4] = dec_bcd;
      mask_d = mask_d | en_in_q;
    end
    seg_err_d = capture && dec_illegal;
    bcd_out_d = load ? frame_q : bcd_out_q;
    if (load)
      bcd_valid_d = 1'b1;
    else if (bcd_valid_q && bcd_ready)
      bcd_valid_d = 1'b0;
    else
      bcd_valid_d = bcd_valid_q;
    // A completed frame that cannot load is lost; the flag is sticky.
    overrun_d = overrun_q || (complete && !load);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg_in_q    <= 7'b0;
      en_in_q     <= 4'b0;
      seg_prev_q  <= 7'b0;
      en_prev_q   <= 4'b0;
      state_q     <= ST_IDLE;
      count_q     <= 8'd0;
      mask_q      <= 4'b0;
      frame_q     <= 16'h0;
      bcd_out_q   <= 16'h0;
      bcd_valid_q <= 1'b0;
      seg_err_q   <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      seg_in_q    <= seg_in_d;
      en_in_q     <= en_in_d;
      seg_prev_q  <= seg_prev_d;
      en_prev_q   <= en_prev_d;
      state_q     <= state_d;
      count_q     <= count_d;
      mask_q      <= mask_d;
      frame_q     <= frame_d;
      bcd_out_q   <= bcd_out_d;
      bcd_valid_q <= bcd_valid_d;
      seg_err_q   <= seg_err_d;
      overrun_q   <= overrun_d;
    end
  end

  assign bcd_out   = bcd_out_q;
  assign bcd_valid = bcd_valid_q;
  assign seg_err   = seg_err_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Directed bench for seg_scan_decoder: frame table plus hand-written
// sequences for debounce, strobe qualification, overrun and reset.
module tb_seg_scan_decoder;

  logic        clk;
  logic        rst;
  logic [6:0]  seg;
  logic [3:0]  dig_en;
  logic [15:0] bcd_out;
  logic        bcd_valid;
  logic        bcd_ready;
  logic        seg_err;
  logic        overrun;

  int n_cmp;
  int n_fail;
  int valid_cnt;
  int err_cnt;

  seg_scan_decoder #(.STABLE_CYCLES(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .seg       (seg),
    .dig_en    (dig_en),
    .bcd_out   (bcd_out),
    .bcd_valid (bcd_valid),
    .bcd_ready (bcd_ready),
    .seg_err   (seg_err),
    .overrun   (overrun)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // monitor: count output pulses away from the active edge
  initial begin
    valid_cnt = 0;
    err_cnt   = 0;
  end
  always @(negedge clk) begin
    if (bcd_valid) valid_cnt = valid_cnt + 1;
    if (seg_err)   err_cnt   = err_cnt + 1;
  end

  typedef struct {
    logic [27:0] segs;     // {digit3, digit2, digit1, digit0} patterns
    logic [15:0] exp_out;
    int          exp_err;
  } frame_vec_t;

  frame_vec_t vecs[4];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp = n_cmp + 1;
    if (act !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // driver: apply one sample for cyc rising edges, return at posedge+1
  task automatic drive(input logic [3:0] en, input logic [6:0] pat, input int cyc);
    seg    = pat;
    dig_en = en;
    repeat (cyc) @(posedge clk);
    #1;
  endtask

  task automatic scan_frame(input logic [27:0] segs);
    for (int i = 0; i < 4; i++) begin
      logic [3:0] en;
      en = 4'(1 << i);
      drive(en, segs[i*7 +: 7], 6);
    end
    drive(4'b0, 7'b0, 6);
  endtask

  initial begin
    int v0, e0;
    n_cmp  = 0;
    n_fail = 0;

    vecs[0] = '{{7'b1011111, 7'b1011011, 7'b0110011, 7'b1111001}, 16'h6543, 0};
    vecs[1] = '{{7'b1110000, 7'b1000001, 7'b0110000, 7'b1111110}, 16'h7F10, 1};
    vecs[2] = '{{7'b1111001, 7'b1101101, 7'b0110000, 7'b1111110}, 16'h3210, 0};
    vecs[3] = '{{7'b1101101, 7'b1110000, 7'b1111011, 7'b1111111}, 16'h2798, 0};

    rst       = 1'b1;
    seg       = 7'b0;
    dig_en    = 4'b0;
    bcd_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_bcd_out", bcd_out, 16'h0000);
    check("reset_valid", 16'(bcd_valid), 16'h0);
    check("reset_seg_err", 16'(seg_err), 16'h0);
    check("reset_overrun", 16'(overrun), 16'h0);
    check("reset_mask", 16'(dut.mask_q), 16'h0);
    rst = 1'b0;
    drive(4'b0, 7'b0, 1);

    // table of full frames with the consumer always ready
    for (int k = 0; k < 4; k++) begin
      v0 = valid_cnt;
      e0 = err_cnt;
      scan_frame(vecs[k].segs);
      check($sformatf("frame%0d_out", k), bcd_out, vecs[k].exp_out);
      check($sformatf("frame%0d_valid_cycles", k), 16'(valid_cnt - v0), 16'd1);
      check($sformatf("frame%0d_seg_err", k), 16'(err_cnt - e0), 16'(vecs[k].exp_err));
      check($sformatf("frame%0d_overrun", k), 16'(overrun), 16'h0);
    end

    // too short a hold: 3 samples, then a change that is also too short
    v0 = valid_cnt;
    drive(4'b0001, 7'b1111110, 3);
    drive(4'b0001, 7'b0110000, 2);
    drive(4'b0000, 7'b0, 3);
    check("short_hold_mask", 16'(dut.mask_q), 16'h0);
    check("short_hold_valid", 16'(valid_cnt - v0), 16'd0);

    // two strobes at once never qualify
    drive(4'b0011, 7'b1111001, 10);
    check("multi_strobe_mask", 16'(dut.mask_q), 16'h0);
    drive(4'b0000, 7'b0, 2);
    check("multi_strobe_out", bcd_out, 16'h2798);

    // stalled consumer: second frame is dropped
    bcd_ready = 1'b0;
    scan_frame(vecs[0].segs);
    check("stall_first_valid", 16'(bcd_valid), 16'h1);
    check("stall_first_out", bcd_out, 16'h6543);
    check("stall_first_overrun", 16'(overrun), 16'h0);
    scan_frame(vecs[2].segs);
    check("stall_held_out", bcd_out, 16'h6543);
    check("stall_overrun", 16'(overrun), 16'h1);
    check("stall_mask_cleared", 16'(dut.mask_q), 16'h0);
    bcd_ready = 1'b1;
    drive(4'b0000, 7'b0, 1);
    check("drain_valid", 16'(bcd_valid), 16'h0);
    check("drain_out", bcd_out, 16'h6543);
    drive(4'b0000, 7'b0, 3);
    check("overrun_sticky", 16'(overrun), 16'h1);

    // reset mid-frame discards the partial frame
    drive(4'b0001, 7'b0110000, 6);
    drive(4'b0010, 7'b1101101, 6);
    drive(4'b0000, 7'b0, 1);
    check("partial_mask", 16'(dut.mask_q), 16'h3);
    rst = 1'b1;
    #1;
    check("async_rst_mask", 16'(dut.mask_q), 16'h0);
    check("async_rst_overrun", 16'(overrun), 16'h0);
    check("async_rst_out", bcd_out, 16'h0000);
    drive(4'b0000, 7'b0, 2);
    rst = 1'b0;
    v0 = valid_cnt;
    scan_frame({7'b1011111, 7'b1110000, 7'b1111111, 7'b1111011});
    check("post_rst_out", bcd_out, 16'h6789);
    check("post_rst_valid_cycles", 16'(valid_cnt - v0), 16'd1);
    check("post_rst_overrun", 16'(overrun), 16'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
